// File: rtl/ifu_predec_fifo_if.sv
// Fetch-to-decode bundle for ifu_predec_fifo: enqueue, dequeue, head predecode/prediction, redirect.
// Latency: none (wires only).
// Backpressure: i_ready/o_ready handshakes carried through; slave is the buffer side, master drives fetch/decode.
interface ifu_predec_fifo_if #(
    parameter int PC_W = 32
);
    logic            i_valid;
    logic            i_ready;
    logic [31:0]     i_instr;
    logic [PC_W-1:0] i_pc;
    logic            i_flush;
    logic            o_valid;
    logic            o_ready;
    logic [31:0]     o_instr;
    logic [PC_W-1:0] o_pc;
    logic            o_bjp;
    logic            o_jal;
    logic            o_jalr;
    logic            o_bxx;
    logic            o_prdt_taken;
    logic [PC_W-1:0] o_prdt_target;
    logic            o_redir_valid;
    logic [PC_W-1:0] o_redir_pc;

    modport slave (
        input  i_valid, i_instr, i_pc, i_flush, o_ready,
        output i_ready, o_valid, o_instr, o_pc, o_bjp, o_jal, o_jalr, o_bxx,
               o_prdt_taken, o_prdt_target, o_redir_valid, o_redir_pc
    );

    modport master (
        output i_valid, i_instr, i_pc, i_flush, o_ready,
        input  i_ready, o_valid, o_instr, o_pc, o_bjp, o_jal, o_jalr, o_bxx,
               o_prdt_taken, o_prdt_target, o_redir_valid, o_redir_pc
    );
endinterface

// File: rtl/ifu_predec_fifo.sv
// Instruction buffer that predecodes branches/jumps and predicts them at enqueue; optional BPU via IFU_PREDEC_BPU_EN.
// Latency: enqueue to head visible 1 cycle (no fall-through); redirect request 1 cycle after a taken enqueue.
// Backpressure: i_ready low when full, during a redirect cycle or a flush; head held while o_valid & !o_ready.
module ifu_predec_fifo #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ifu_predec_fifo_if.slave   io_fifo
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            bjp;
        logic            jal;
        logic            jalr;
        logic            bxx;
        logic            taken;
        logic [PC_W-1:0] target;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_redir_pend;
    logic [PC_W-1:0] r_redir_pc;

    logic [6:0]      w_opcode;
    logic            w_jal;
    logic            w_jalr;
    logic            w_bxx;
    logic [PC_W-1:0] w_pc_plus4;
    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic            w_full;
    logic            w_empty;
    logic            w_i_ready;
    logic            w_enq;
    logic            w_deq;
    entry_t          w_entry;
    entry_t          w_head;

    assign w_opcode   = io_fifo.i_instr[6:0];
    assign w_jal      = (w_opcode == 7'b1101111);
    assign w_jalr     = (w_opcode == 7'b1100111);
    assign w_bxx      = (w_opcode == 7'b1100011);
    assign w_pc_plus4 = io_fifo.i_pc + PC_W'(4);

`ifdef IFU_PREDEC_BPU_EN
    logic [31:0]     w_imm_j32;
    logic [31:0]     w_imm_i32;
    logic [31:0]     w_imm_b32;
    logic [PC_W-1:0] w_imm_j;
    logic [PC_W-1:0] w_imm_i;
    logic [PC_W-1:0] w_imm_b;
    logic [4:0]      w_rs1;

    assign w_imm_j32 = {{11{io_fifo.i_instr[31]}}, io_fifo.i_instr[31], io_fifo.i_instr[19:12],
                        io_fifo.i_instr[20], io_fifo.i_instr[30:21], 1'b0};
    assign w_imm_i32 = {{20{io_fifo.i_instr[31]}}, io_fifo.i_instr[31:20]};
    assign w_imm_b32 = {{19{io_fifo.i_instr[31]}}, io_fifo.i_instr[31], io_fifo.i_instr[7],
                        io_fifo.i_instr[30:25], io_fifo.i_instr[11:8], 1'b0};
    // Sign-extend (or truncate) the 32-bit immediates to the PC width.
    assign w_imm_j   = PC_W'(signed'(w_imm_j32));
    assign w_imm_i   = PC_W'(signed'(w_imm_i32));
    assign w_imm_b   = PC_W'(signed'(w_imm_b32));
    assign w_rs1     = io_fifo.i_instr[19:15];
`endif

    // Static prediction of the incoming instruction; not-taken falls through to pc+4.
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc_plus4;
`ifdef IFU_PREDEC_BPU_EN
        if (w_jal) begin
            w_taken  = 1'b1;
            w_target = io_fifo.i_pc + w_imm_j;
        end else if (w_jalr && (w_rs1 == 5'd0)) begin
            w_taken  = 1'b1;
            w_target = w_imm_i;
        end else if (w_bxx && io_fifo.i_instr[31]) begin
            // backward branch: sign bit of the B immediate is the instruction MSB
            w_taken  = 1'b1;
            w_target = io_fifo.i_pc + w_imm_b;
        end
`endif
    end

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // rst_n gates ready so nothing is accepted while reset is held
    assign w_i_ready = rst_n & ~w_full & ~r_redir_pend & ~io_fifo.i_flush;
    assign w_enq     = io_fifo.i_valid & w_i_ready;
    assign w_deq     = ~w_empty & io_fifo.o_ready & ~io_fifo.i_flush;

    assign w_entry = {io_fifo.i_instr, io_fifo.i_pc, (w_jal | w_jalr | w_bxx),
                      w_jal, w_jalr, w_bxx, w_taken, w_target};

    // Pointer and occupancy bookkeeping; flush overrides enqueue/dequeue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (io_fifo.i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: written on accepted enqueue, fully cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_enq) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // One-cycle redirect pulse after a predicted-taken enqueue; blocks enqueue while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
        end else if (io_fifo.i_flush) begin
            r_redir_pend <= 1'b0;
        end else if (w_enq && w_taken) begin
            r_redir_pend <= 1'b1;
            r_redir_pc   <= w_target;
        end else begin
            r_redir_pend <= 1'b0;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign io_fifo.i_ready       = w_i_ready;
    assign io_fifo.o_valid       = ~w_empty;
    assign io_fifo.o_instr       = w_head.instr;
    assign io_fifo.o_pc          = w_head.pc;
    assign io_fifo.o_bjp         = w_head.bjp;
    assign io_fifo.o_jal         = w_head.jal;
    assign io_fifo.o_jalr        = w_head.jalr;
    assign io_fifo.o_bxx         = w_head.bxx;
    assign io_fifo.o_prdt_taken  = w_head.taken;
    assign io_fifo.o_prdt_target = w_head.target;
    assign io_fifo.o_redir_valid = r_redir_pend;
    assign io_fifo.o_redir_pc    = r_redir_pc;
endmodule

// File: tb/tb_ifu_predec_fifo.sv
// Scoreboard bench for ifu_predec_fifo: directed enqueues push expected head entries, a monitor checks dequeues.
// Latency: checks head visibility one cycle after enqueue and the one-cycle redirect pulse.
// Backpressure: exercises full, redirect stall, flush and mid-operation reset.
module tb_ifu_predec_fifo;
`ifdef IFU_PREDEC_BPU_EN
    localparam logic BPU = 1'b1;
`else
    localparam logic BPU = 1'b0;
`endif
    localparam logic [31:0] ADDI = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jal;
        logic        jalr;
        logic        bxx;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   waits;
    exp_t exp_q[$];

    ifu_predec_fifo_if #(.PC_W(32)) bus ();

    ifu_predec_fifo #(.DEPTH(4), .PC_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_fifo (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic jal,
                            input logic jalr, input logic bxx, input logic tk, input logic [31:0] tgt);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.jal   = jal;
        e.jalr  = jalr;
        e.bxx   = bxx;
        e.taken = BPU ? tk : 1'b0;
        e.tgt   = BPU ? tgt : pc + 32'd4;
        exp_q.push_back(e);
    endtask

    // Offer one instruction; returns the number of cycles it waited for i_ready.
    task automatic enq(input logic [31:0] instr, input logic [31:0] pc, input logic jal,
                       input logic jalr, input logic bxx, input logic tk, input logic [31:0] tgt,
                       output int w);
        bit done = 1'b0;
        w = 0;
        bus.i_valid = 1'b1;
        bus.i_instr = instr;
        bus.i_pc    = pc;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (bus.i_ready) begin
                push_exp(instr, pc, jal, jalr, bxx, tk, tgt);
                done = 1'b1;
            end else begin
                w++;
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        chk("enq_accept", done, 1);
    endtask

    task automatic drain();
        bus.o_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            #1;
            if (!bus.o_valid) break;
        end
        bus.o_ready = 1'b0;
        chk("drain_valid", bus.o_valid, 0);
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Called in the cycle right after a taken-capable enqueue.
    task automatic chk_redirect(input logic [31:0] tgt);
        chk("head_vld_next", bus.o_valid, 1);
        chk("redir_vld", bus.o_redir_valid, BPU);
        chk("redir_pc", bus.o_redir_valid ? bus.o_redir_pc : 32'h0, BPU ? tgt : 32'h0);
        chk("ready_in_redir", bus.i_ready, !BPU);
        @(posedge clk);
        #1;
        chk("redir_clear", bus.o_redir_valid, 0);
        chk("ready_after_redir", bus.i_ready, 1);
    endtask

    // Monitor: a head with o_valid & o_ready at this falling edge is dequeued at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid && bus.o_ready && !bus.i_flush) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", bus.o_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_instr", bus.o_instr, e.instr);
                    chk("head_pc", bus.o_pc, e.pc);
                    chk("head_jal", bus.o_jal, e.jal);
                    chk("head_jalr", bus.o_jalr, e.jalr);
                    chk("head_bxx", bus.o_bxx, e.bxx);
                    chk("head_bjp", bus.o_bjp, e.jal | e.jalr | e.bxx);
                    chk("head_taken", bus.o_prdt_taken, e.taken);
                    chk("head_target", bus.o_prdt_target, e.tgt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_instr = '0;
        bus.i_pc    = '0;
        bus.i_flush = 1'b0;
        bus.o_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state while held
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_i_ready", bus.i_ready, 0);
        chk("rst_redir", bus.o_redir_valid, 0);
        chk("rst_o_pc", bus.o_pc, 0);
        chk("rst_o_instr", bus.o_instr, 0);
        chk("rst_target", bus.o_prdt_target, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.i_ready, 1);
        chk("post_rst_empty", bus.o_valid, 0);
        @(posedge clk);
        #1;

        // jal x1,+8
        enq(32'h008000EF, 32'h8000_0000, 1, 0, 0, 1, 32'h8000_0008, waits);
        chk_redirect(32'h8000_0008);
        drain();

        // beq x0,x0,-4 (backward)
        enq(32'hFE000EE3, 32'h8000_0010, 0, 0, 1, 1, 32'h8000_000C, waits);
        chk_redirect(32'h8000_000C);
        drain();

        // jalr x0,0x100(x0) then jalr x0,0x100(x5)
        enq(32'h10000067, 32'h8000_0020, 0, 1, 0, 1, 32'h0000_0100, waits);
        enq(32'h10028067, 32'h8000_0030, 0, 1, 0, 0, 32'h8000_0034, waits);
        drain();

        // fill to full with stalled consumer, then stream the rest while draining
        for (int k = 0; k < 4; k++) begin
            enq(ADDI, 32'(k * 4), 0, 0, 0, 0, 32'(k * 4 + 4), waits);
        end
        chk("full_ready", bus.i_ready, 0);
        chk("hold_pc_a", bus.o_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("hold_pc_b", bus.o_pc, 32'h0);
        chk("hold_valid", bus.o_valid, 1);
        bus.o_ready = 1'b1;
        enq(ADDI, 32'h10, 0, 0, 0, 0, 32'h14, waits);
        enq(ADDI, 32'h14, 0, 0, 0, 0, 32'h18, waits);
        drain();

        // flush with simultaneous enqueue and dequeue attempts
        for (int k = 0; k < 3; k++) begin
            enq(ADDI, 32'h100 + 32'(k * 4), 0, 0, 0, 0, 32'h104 + 32'(k * 4), waits);
        end
        bus.i_valid = 1'b1;
        bus.i_instr = ADDI;
        bus.i_pc    = 32'h200;
        bus.o_ready = 1'b1;
        bus.i_flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush_iready", bus.i_ready, 0);
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_ovalid", bus.o_valid, 0);
        chk("flush_redir", bus.o_redir_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_stays_empty", bus.o_valid, 0);
        bus.o_ready = 1'b0;
        enq(ADDI, 32'h400, 0, 0, 0, 0, 32'h404, waits);
        drain();

        // reset while full with a redirect pending
        for (int k = 0; k < 3; k++) begin
            enq(ADDI, 32'h500 + 32'(k * 4), 0, 0, 0, 0, 32'h504 + 32'(k * 4), waits);
        end
        enq(32'h008000EF, 32'h50C, 1, 0, 0, 1, 32'h514, waits);
        chk("pre_rst_redir", bus.o_redir_valid, BPU);
        chk("pre_rst_full", bus.i_ready, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", bus.o_valid, 0);
        chk("mid_rst_redir", bus.o_redir_valid, 0);
        chk("mid_rst_ready", bus.i_ready, 0);
        chk("mid_rst_pc", bus.o_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enq(ADDI, 32'h300, 0, 0, 0, 0, 32'h304, waits);
        chk("first_enq_wait", waits, 0);
        chk("first_head_valid", bus.o_valid, 1);
        chk("first_head_pc", bus.o_pc, 32'h300);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
